// File: rtl/viterbi_ctrl_pkg.sv
// Shared Viterbi controller definitions: read-FSM states and the default frame depth.
package viterbi_ctrl_pkg;
  localparam int VITERBI_DEPTH = 8;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_TB   = 2'd2
  } rd_state_e;
endpackage

// File: rtl/tb_frame_scheduler_if.sv
// Handshake bundle between the frame scheduler and the ACS front end / survivor datapath.
// VITERBI_FLUSH_EN adds the flush input used to close partial frames.
interface tb_frame_scheduler_if
  import viterbi_ctrl_pkg::*;
#(
  parameter int DEPTH = VITERBI_DEPTH,
  parameter int AW    = $clog2(DEPTH)
);
  logic          in_valid;
  logic          in_ready;
  logic          wr_en;
  logic          wr_bank;
  logic [AW-1:0] wr_addr;
  logic          min_start;
  logic          min_done;
  logic          tb_en;
  logic          tb_bank;
  logic [AW-1:0] tb_addr;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;

`ifdef VITERBI_FLUSH_EN
  logic          flush;

  modport slave (
    input  in_valid, min_done, out_ready, flush,
    output in_ready, wr_en, wr_bank, wr_addr, min_start, tb_en, tb_bank, tb_addr,
           out_valid, out_last, busy
  );
  modport master (
    output in_valid, min_done, out_ready, flush,
    input  in_ready, wr_en, wr_bank, wr_addr, min_start, tb_en, tb_bank, tb_addr,
           out_valid, out_last, busy
  );
`else
  modport slave (
    input  in_valid, min_done, out_ready,
    output in_ready, wr_en, wr_bank, wr_addr, min_start, tb_en, tb_bank, tb_addr,
           out_valid, out_last, busy
  );
  modport master (
    output in_valid, min_done, out_ready,
    input  in_ready, wr_en, wr_bank, wr_addr, min_start, tb_en, tb_bank, tb_addr,
           out_valid, out_last, busy
  );
`endif
endinterface

// File: rtl/tb_read_seq.sv
// Read sequencer: kicks off the best-state search on a full bank, walks traceback
// addresses downward and holds the output valid/last register under back-pressure.
module tb_read_seq
  import viterbi_ctrl_pkg::*;
#(
  parameter int DEPTH = VITERBI_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    full,
  input  logic [AW-1:0] start_addr,
  input  logic          min_done,
  input  logic          out_ready,
  output logic          min_start,
  output logic          tb_en,
  output logic [AW-1:0] tb_addr,
  output logic          rd_bank,
  output logic          rd_clr,
  output logic          rd_active,
  output logic          out_valid,
  output logic          out_last
);
  rd_state_e state;
  logic      adv;

  // The output register can take a new bit when empty or being drained this cycle.
  assign adv       = !out_valid || out_ready;
  assign min_start = (state == R_IDLE) && full[rd_bank];
  assign tb_en     = (state == R_TB) && adv;
  assign rd_clr    = tb_en && (tb_addr == '0);
  assign rd_active = (state != R_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= R_IDLE;
      rd_bank   <= 1'b0;
      tb_addr   <= AW'(DEPTH - 1);
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (adv) begin
        out_valid <= tb_en;
        out_last  <= rd_clr;
      end
      case (state)
        R_IDLE: if (min_start) state <= R_WAIT;
        R_WAIT: if (min_done) begin
          state   <= R_TB;
          tb_addr <= start_addr;
        end
        R_TB: if (tb_en) begin
          tb_addr <= tb_addr - AW'(1);
          if (rd_clr) begin
            state   <= R_IDLE;
            rd_bank <= ~rd_bank;
            tb_addr <= AW'(DEPTH - 1);
          end
        end
        default: state <= R_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/tb_frame_scheduler.sv
// Ping-pong survivor-memory frame scheduler: write counter and bank full flags here,
// read sequencing in tb_read_seq. VITERBI_FLUSH_EN enables closing partial frames.
module tb_frame_scheduler
  import viterbi_ctrl_pkg::*;
#(
  parameter int DEPTH = VITERBI_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input logic                  clk,
  input logic                  rst_n,
  tb_frame_scheduler_if.slave  bus
);
  logic [1:0]    full;
  logic [1:0]    set_mask, clr_mask;
  logic          wr_bank;
  logic [AW-1:0] wr_cnt;
  logic          accept, close;
  logic          rd_bank, rd_clr, rd_active;
  logic [AW-1:0] start_addr;

  assign accept      = bus.in_valid && bus.in_ready;
  assign bus.in_ready = !full[wr_bank];
  assign bus.wr_en   = accept;
  assign bus.wr_bank = wr_bank;
  assign bus.wr_addr = wr_cnt;
  assign bus.tb_bank = rd_bank;
  assign bus.busy    = (|full) || rd_active;

`ifdef VITERBI_FLUSH_EN
  logic [1:0][AW:0] len;
  logic [AW:0]      close_len;

  // A flush on an accepting cycle keeps that step; an idle flush on an empty bank does nothing.
  assign close      = (accept && ((wr_cnt == AW'(DEPTH - 1)) || bus.flush)) ||
                      (bus.flush && !accept && (wr_cnt != '0));
  assign close_len  = {1'b0, wr_cnt} + (AW + 1)'(accept);
  assign start_addr = AW'(len[rd_bank] - (AW + 1)'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     len <= '0;
    else if (close) len[wr_bank] <= close_len;
  end
`else
  assign close      = accept && (wr_cnt == AW'(DEPTH - 1));
  assign start_addr = AW'(DEPTH - 1);
`endif

  // Writer only closes a non-full bank and reader only frees a full one, so the masks never collide.
  assign set_mask = close  ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;
  assign clr_mask = rd_clr ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full    <= '0;
      wr_bank <= 1'b0;
      wr_cnt  <= '0;
    end else begin
      full <= (full & ~clr_mask) | set_mask;
      if (close) begin
        wr_bank <= ~wr_bank;
        wr_cnt  <= '0;
      end else if (accept) begin
        wr_cnt  <= wr_cnt + AW'(1);
      end
    end
  end

  tb_read_seq #(.DEPTH(DEPTH), .AW(AW)) u_rd (
    .clk        (clk),
    .rst_n      (rst_n),
    .full       (full),
    .start_addr (start_addr),
    .min_done   (bus.min_done),
    .out_ready  (bus.out_ready),
    .min_start  (bus.min_start),
    .tb_en      (bus.tb_en),
    .tb_addr    (bus.tb_addr),
    .rd_bank    (rd_bank),
    .rd_clr     (rd_clr),
    .rd_active  (rd_active),
    .out_valid  (bus.out_valid),
    .out_last   (bus.out_last)
  );
endmodule
